// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the miniRV execute-stage ALU.
//   ALU_W  : datapath width (32)
//   alu_op_e : operation codes ALU_ADD .. ALU_BGEU (4 bits)
//   alu_sel_e: operand-B select codes ALU_RS2 / ALU_EXT / ALU_FOUR (3 bits)
package alu_pkg;

   localparam int unsigned ALU_W = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_BEQ  = 4'd10,
      ALU_BNE  = 4'd11,
      ALU_BLT  = 4'd12,
      ALU_BGE  = 4'd13,
      ALU_BLTU = 4'd14,
      ALU_BGEU = 4'd15
   } alu_op_e;

   typedef enum logic [2:0] {
      ALU_RS2  = 3'd0,
      ALU_EXT  = 3'd1,
      ALU_FOUR = 3'd2
   } alu_sel_e;

endpackage

// File: rtl/alu_cmp.sv
// alu_cmp: magnitude/equality comparator shared by SLT/SLTU and the branch ops.
//   a, b        : 32-bit operands
//   eq          : a == b
//   lt_signed   : a < b, two's complement
//   lt_unsigned : a < b, unsigned
module alu_cmp
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   output logic             eq,
   output logic             lt_signed,
   output logic             lt_unsigned
);

   always_comb begin
      eq          = (a == b);
      lt_signed   = ($signed(a) < $signed(b));
      lt_unsigned = (a < b);
   end

endmodule

// File: rtl/alu.sv
// alu: single-cycle-latency 32-bit integer ALU for the miniRV execute stage.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   A        : operand A
//   rd2      : register-file read port 2 (operand B when sel = ALU_RS2)
//   sext     : sign-extended immediate (operand B when sel = ALU_EXT)
//   sel      : operand-B select (ALU_FOUR -> 4, unused codes -> 0)
//   alu_op   : operation code (alu_pkg::alu_op_e)
//   C        : registered result
//   f        : registered branch-taken flag
// Build option: define ALU_SLT_EN to include SLT/SLTU; otherwise ops 8/9
// produce C = 0, f = 0.
module alu
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [ALU_W-1:0] A,
   input  logic [ALU_W-1:0] rd2,
   input  logic [ALU_W-1:0] sext,
   input  logic [2:0]       sel,
   input  logic [3:0]       alu_op,
   output logic [ALU_W-1:0] C,
   output logic             f
);

   logic [ALU_W-1:0] b;
   logic [4:0]       shamt;
   logic [ALU_W-1:0] diff;
   logic             eq;
   logic             lt_s;
   logic             lt_u;
   logic [ALU_W-1:0] c_d, c_q;
   logic             f_d, f_q;

   always_comb begin
      b = '0;
      case (sel)
         ALU_RS2:  b = rd2;
         ALU_EXT:  b = sext;
         ALU_FOUR: b = 32'd4;
         default:  b = '0;
      endcase
   end

   // Shifts only look at the low five bits of B.
   assign shamt = b[4:0];
   assign diff  = A - b;

   alu_cmp u_cmp (
      .a           (A),
      .b           (b),
      .eq          (eq),
      .lt_signed   (lt_s),
      .lt_unsigned (lt_u)
   );

   always_comb begin
      c_d = '0;
      f_d = 1'b0;
      case (alu_op)
         ALU_ADD:  c_d = A + b;
         ALU_SUB:  c_d = diff;
         ALU_AND:  c_d = A & b;
         ALU_OR:   c_d = A | b;
         ALU_XOR:  c_d = A ^ b;
         ALU_SLL:  c_d = A << shamt;
         ALU_SRL:  c_d = A >> shamt;
         ALU_SRA:  c_d = ALU_W'($signed(A) >>> shamt);
`ifdef ALU_SLT_EN
         ALU_SLT:  c_d = {31'b0, lt_s};
         ALU_SLTU: c_d = {31'b0, lt_u};
`endif
         ALU_BEQ:  begin c_d = diff; f_d = eq;    end
         ALU_BNE:  begin c_d = diff; f_d = !eq;   end
         ALU_BLT:  begin c_d = diff; f_d = lt_s;  end
         ALU_BGE:  begin c_d = diff; f_d = !lt_s; end
         ALU_BLTU: begin c_d = diff; f_d = lt_u;  end
         ALU_BGEU: begin c_d = diff; f_d = !lt_u; end
         default:  begin c_d = '0;   f_d = 1'b0;  end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q <= '0;
         f_q <= 1'b0;
      end else begin
         c_q <= c_d;
         f_q <= f_d;
      end
   end

   assign C = c_q;
   assign f = f_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed table plus randomized checks of alu against a reference model.
module tb_alu;
   import alu_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] A, rd2, sext;
   logic [2:0]  sel;
   logic [3:0]  alu_op;
   logic [31:0] C;
   logic        f;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] a;
      logic [31:0] rd2;
      logic [31:0] sext;
      logic [2:0]  sel;
      logic [3:0]  op;
      logic [31:0] exp_c;
      logic        exp_f;
   } vec_t;

   vec_t vecs[$];

   alu dut (
      .clk    (clk),
      .rst    (rst),
      .A      (A),
      .rd2    (rd2),
      .sext   (sext),
      .sel    (sel),
      .alu_op (alu_op),
      .C      (C),
      .f      (f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model written directly from the operation table.
   function automatic void model(input logic [31:0] a, input logic [31:0] r2,
                                 input logic [31:0] sx, input logic [2:0] s,
                                 input logic [3:0] op,
                                 output logic [31:0] c, output logic fl);
      longint unsigned ua, ub;
      longint          sa, sb;
      int unsigned     sh;
      logic [31:0]     bv;
      bv = (s == 3'd0) ? r2 : (s == 3'd1) ? sx : (s == 3'd2) ? 32'd4 : 32'd0;
      ua = longint'(a);
      ub = longint'(bv);
      sa = longint'($signed(a));
      sb = longint'($signed(bv));
      sh = bv % 32;
      c  = 32'd0;
      fl = 1'b0;
      case (op)
         4'd0: c = 32'(ua + ub);
         4'd1: c = 32'(ua - ub);
         4'd2: c = a & bv;
         4'd3: c = a | bv;
         4'd4: c = a ^ bv;
         4'd5: c = 32'(ua * (64'd1 << sh));
         4'd6: c = 32'(ua / (64'd1 << sh));
         4'd7: c = 32'(sa >>> sh);
`ifdef ALU_SLT_EN
         4'd8: c = (sa < sb) ? 32'd1 : 32'd0;
         4'd9: c = (ua < ub) ? 32'd1 : 32'd0;
`endif
         default: begin
            c = 32'(ua - ub);
            case (op)
               4'd10: fl = (ua == ub);
               4'd11: fl = (ua != ub);
               4'd12: fl = (sa < sb);
               4'd13: fl = (sa >= sb);
               4'd14: fl = (ua < ub);
               4'd15: fl = (ua >= ub);
               default: begin c = 32'd0; fl = 1'b0; end
            endcase
         end
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] ec, input logic ef);
      checks++;
      if (C !== ec) begin
         errors++;
         $display("FAIL %s C: got %08h expected %08h", name, C, ec);
      end
      checks++;
      if (f !== ef) begin
         errors++;
         $display("FAIL %s f: got %0b expected %0b", name, f, ef);
      end
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b2,
                        input logic [31:0] sx, input logic [2:0] s, input logic [3:0] op);
      @(negedge clk);
      rst = r; A = a; rd2 = b2; sext = sx; sel = s; alu_op = op;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] mc;
   logic        mf;
   logic [31:0] slt_exp;

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; A = 32'd7; rd2 = 32'd1; sext = 32'd0; sel = 3'd0; alu_op = 4'd0;

`ifdef ALU_SLT_EN
      slt_exp = 32'd1;
`else
      slt_exp = 32'd0;
`endif

      //                a             rd2           sext          sel   op     C             f
      vecs.push_back('{32'd7,        32'd1,        32'd0,        3'd0, 4'd0,  32'd8,        1'b0});
      vecs.push_back('{32'd7,        32'd1,        32'd0,        3'd0, 4'd6,  32'd3,        1'b0});
      vecs.push_back('{32'd7,        32'd1,        32'd0,        3'd0, 4'd5,  32'd14,       1'b0});
      vecs.push_back('{32'h80000007, 32'd1,        32'd0,        3'd0, 4'd7,  32'hC0000003, 1'b0});
      vecs.push_back('{32'd7,        32'h21,       32'd0,        3'd0, 4'd5,  32'd14,       1'b0});
      vecs.push_back('{32'h80000000, 32'd31,       32'd0,        3'd0, 4'd7,  32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,        3'd0, 4'd12, 32'hFFFFFFFE, 1'b1});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,        3'd0, 4'd14, 32'hFFFFFFFE, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,        3'd0, 4'd15, 32'hFFFFFFFE, 1'b1});
      vecs.push_back('{32'd5,        32'd5,        32'd0,        3'd0, 4'd10, 32'd0,        1'b1});
      vecs.push_back('{32'd5,        32'd5,        32'd0,        3'd0, 4'd11, 32'd0,        1'b0});
      vecs.push_back('{32'd5,        32'd5,        32'd0,        3'd0, 4'd13, 32'd0,        1'b1});
      vecs.push_back('{32'h10,       32'd0,        32'hFFFFFFFC, 3'd1, 4'd0,  32'hC,        1'b0});
      vecs.push_back('{32'h100,      32'd9,        32'd0,        3'd2, 4'd0,  32'h104,      1'b0});
      vecs.push_back('{32'd5,        32'd9,        32'd9,        3'd5, 4'd0,  32'd5,        1'b0});
      vecs.push_back('{32'd0,        32'd1,        32'd0,        3'd0, 4'd1,  32'hFFFFFFFF, 1'b0});
      vecs.push_back('{32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        3'd0, 4'd4,  32'h0FF00FF0, 1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,        3'd0, 4'd8,  slt_exp,      1'b0});
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'd0,        3'd0, 4'd9,  32'd0,        1'b0});

      // Reset held for two cycles with a live ADD on the inputs.
      drive(1'b1, 32'd7, 32'd1, 32'd0, 3'd0, 4'd0);
      check("reset0", 32'd0, 1'b0);
      drive(1'b1, 32'd7, 32'd1, 32'd0, 3'd0, 4'd0);
      check("reset1", 32'd0, 1'b0);

      foreach (vecs[i]) begin
         drive(1'b0, vecs[i].a, vecs[i].rd2, vecs[i].sext, vecs[i].sel, vecs[i].op);
         check($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_f);
      end

      // Mid-stream reset: ADD result, then reset overrides, then resume.
      drive(1'b0, 32'd20, 32'd22, 32'd0, 3'd0, 4'd0);
      check("mid_add", 32'd42, 1'b0);
      drive(1'b1, 32'd9, 32'd2, 32'd0, 3'd0, 4'd1);
      check("mid_rst", 32'd0, 1'b0);
      drive(1'b0, 32'd9, 32'd2, 32'd0, 3'd0, 4'd1);
      check("mid_resume", 32'd7, 1'b0);
      drive(1'b0, 32'd3, 32'd3, 32'd0, 3'd0, 4'd10);
      check("mid_beq", 32'd0, 1'b1);

      // Randomized operations, with edge-value operands and occasional reset.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ra, rb, rs;
         logic [2:0]  rsel;
         logic [3:0]  rop;
         logic        rr;
         ra   = ($urandom_range(0, 4) == 0) ? 32'h80000000 : 32'($urandom);
         rb   = ($urandom_range(0, 4) == 0) ? ra : 32'($urandom);
         rs   = 32'($urandom);
         rsel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         rop  = 4'($urandom_range(0, 15));
         rr   = ($urandom_range(0, 31) == 0);
         if (rr) begin
            mc = 32'd0;
            mf = 1'b0;
         end else begin
            model(ra, rb, rs, rsel, rop, mc, mf);
         end
         drive(rr, ra, rb, rs, rsel, rop);
         check($sformatf("rand%0d_op%0d_sel%0d", n, rop, rsel), mc, mf);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

Single-cycle-latency 32-bit integer ALU for the miniRV CPU datapath, sitting in the execute stage. It takes operand A and selects operand B from the register-file read data (`rd2`) or the sign-extended immediate (`sext`). It produces a registered 32-bit result `C` and a registered branch-condition flag `f` used by next-PC logic.

## Interface
- No parameters; data width fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `A`  in  32  operand A (rs1 or PC, muxed upstream)
- `rd2`  in  32  register-file read port 2 (rs2)
- `sext`  in  32  sign-extended immediate
- `sel`  in  3  operand-B select
- `alu_op`  in  4  operation code
- `C`  out  32  registered result
- `f`  out  1  registered branch-taken flag
- One clock; reset is synchronous and active-high.

## Operation
- Operand B by `sel`:
  - `ALU_RS2` = 3'd0 → `rd2`
  - `ALU_EXT` = 3'd1 → `sext`
  - `ALU_FOUR` = 3'd2 → 32'd4
  - 3'd3–3'd7 → 32'd0
- `alu_op` encodings, with result C and flag f:
  - 0 `ALU_ADD`: C = A+B, mod 2^32; f = 0
  - 1 `ALU_SUB`: C = A−B, mod 2^32; f = 0
  - 2 `ALU_AND`, 3 `ALU_OR`, 4 `ALU_XOR`: bitwise; f = 0
  - 5 `ALU_SLL`: C = A << B[4:0]
  - 6 `ALU_SRL`: logical right shift by B[4:0], zero fill
  - 7 `ALU_SRA`: arithmetic right shift by B[4:0], fills with A[31]
  - B[31:5] are ignored for all shifts.
  - 8 `ALU_SLT`: C = {31'b0, signed A<B}
  - 9 `ALU_SLTU`: C = {31'b0, unsigned A<B}
  - 10 `ALU_BEQ`: f = (A==B)
  - 11 `ALU_BNE`: f = (A!=B)
  - 12 `ALU_BLT`: f = signed A<B
  - 13 `ALU_BGE`: f = signed A>=B
  - 14 `ALU_BLTU`: f = unsigned A<B
  - 15 `ALU_BGEU`: f = unsigned A>=B
  - For ops 10–15, C = A−B.
- f = 0 for every op 0–9.
- No overflow or carry outputs; overflow wraps silently.

## Timing
- All inputs are sampled on the rising edge of `clk`; C and f are valid after that edge (latency 1 cycle).
- A new operation is accepted every cycle; no handshake and no stall input.
- `rst` high at an edge forces C = 32'd0 and f = 0, overriding any operation in that cycle.
- The first result after reset is released reflects inputs sampled at the first edge with `rst` low.
- Outputs hold between edges; input glitches mid-cycle are invisible.

## Configuration
- Macro `ALU_SLT_EN`:
  - Defined: ops 8/9 (SLT/SLTU) behave as specified.
  - Undefined: SLT/SLTU logic is omitted; ops 8/9 yield C = 32'd0, f = 0.
- Branch compares are always present.

## Structure
- Shared package `alu_pkg`: `alu_op` codes (`ALU_ADD`…`ALU_BGEU`), `sel` codes (`ALU_RS2`, `ALU_EXT`, `ALU_FOUR`), and width constant 32.
- One sub-module `alu_cmp`:
  - Inputs A, B.
  - Outputs eq, lt_signed, lt_unsigned.
  - Shared by SLT/SLTU and all branch ops.
- Everything else, including the shifter, is inline combinational logic feeding the output register.

## Test plan
- Reset: `rst`=1 for 2 cycles with any inputs → C = 0, f = 0.
- ADD: A=7, rd2=1, sel=`ALU_RS2`, op=`ALU_ADD` → next cycle C = 8, f = 0.
- Shifts with A=7, rd2=1:
  - `ALU_SRL` → C = 3
  - `ALU_SLL` → C = 14
  - A=0x80000007, `ALU_SRA` → C = 0xC0000003
  - rd2=0x21 with `ALU_SLL` → C = 14 (only B[4:0] used)
- Branch, A=0xFFFFFFFF, rd2=1:
  - `ALU_BLT` → f = 1
  - `ALU_BLTU` → f = 0
  - `ALU_BGEU` → f = 1
  - A=rd2=5 with `ALU_BEQ` → f = 1, C = 0
- Operand select: sel=`ALU_EXT`, sext=0xFFFFFFFC, A=0x10, op=`ALU_ADD` → C = 0xC; sel=`ALU_FOUR`, A=0x100 → C = 0x104.
- Mid-stream reset: issue ADD, assert `rst` at the next edge → C = 0 that cycle; deassert → following ops resume with 1-cycle latency.
